// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Optional round-robin tie-break is enabled by defining MEM_ARB_RR_EN (default: LSU wins ties).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_we,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              owner_lsu_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              grant_lsu_s;
  logic              accept_s;

`ifdef MEM_ARB_RR_EN
  logic last_lsu_r;

  // Tie goes to whoever lost the previous grant; a lone requester always wins.
  always_comb begin
    grant_lsu_s = lsu_req_valid;
    if (if_req_valid && lsu_req_valid) begin
      grant_lsu_s = ~last_lsu_r;
    end else begin
      grant_lsu_s = lsu_req_valid;
    end
  end

  // Remember the most recent grant for the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_lsu_r <= 1'b0;
    end else if (accept_s) begin
      last_lsu_r <= grant_lsu_s;
    end else begin
      last_lsu_r <= last_lsu_r;
    end
  end
`else
  assign grant_lsu_s = lsu_req_valid;
`endif

  assign accept_s = (state_r == IDLE) && (if_req_valid || lsu_req_valid);

  // Transaction sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? ISSUE : IDLE;
      ISSUE:   state_nxt_s = mem_req_ready ? WAIT : ISSUE;
      WAIT:    state_nxt_s = mem_rsp_valid ? RESP : WAIT;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched request fields and captured response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_lsu_r <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      wmask_r     <= '0;
      rsp_data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_lsu_r <= grant_lsu_s;
        we_r        <= grant_lsu_s ? lsu_req_we : 1'b0;
        addr_r      <= grant_lsu_s ? lsu_req_addr : if_req_addr;
        wdata_r     <= grant_lsu_s ? lsu_req_wdata : '0;
        wmask_r     <= grant_lsu_s ? lsu_req_wmask : '0;
      end
      if ((state_r == WAIT) && mem_rsp_valid) begin
        rsp_data_r <= mem_rsp_data;
      end
    end
  end

  // Reset masks every output so nothing leaks from an interrupted transaction.
  assign if_req_ready  = ~reset && (state_r == IDLE) && if_req_valid && ~grant_lsu_s;
  assign lsu_req_ready = ~reset && (state_r == IDLE) && lsu_req_valid && grant_lsu_s;
  assign mem_req_valid = ~reset && (state_r == ISSUE);
  assign mem_req_we    = ~reset && we_r;
  assign mem_req_addr  = reset ? '0 : addr_r;
  assign mem_req_wdata = reset ? '0 : wdata_r;
  assign mem_req_wmask = reset ? '0 : wmask_r;
  assign if_rsp_valid  = ~reset && (state_r == RESP) && ~owner_lsu_r;
  assign lsu_rsp_valid = ~reset && (state_r == RESP) && owner_lsu_r;
  assign if_rsp_data   = reset ? '0 : rsp_data_r;
  assign lsu_rsp_data  = reset ? '0 : rsp_data_r;
  assign busy          = ~reset && (state_r != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transactions checked against a transaction-level arbiter model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_data;
  logic [MW-1:0] lsu_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, busy;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data;
  logic [MW-1:0] mem_req_wmask;

  int checks = 0;
  int errors = 0;
  bit rr_en;
  bit last_lsu;
  logic [3:0] order;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_rsp"}, if_rsp_valid, 1'b0);
    chk({tag, "_lsu_rsp"}, lsu_rsp_valid, 1'b0);
    chk({tag, "_mem_req"}, mem_req_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // One complete transaction: d extra ISSUE stall cycles, w extra WAIT cycles.
  task automatic do_txn(input bit iv, input bit lv, input bit lwe,
                        input logic [AW-1:0] ia, input logic [AW-1:0] la,
                        input logic [DW-1:0] lwd, input logic [MW-1:0] lm,
                        input int d, input int w, input logic [DW-1:0] rdata, input bit hold);
    bit win_lsu;
    if (iv && lv) win_lsu = rr_en ? !last_lsu : 1'b1;
    else          win_lsu = lv;
    if (rr_en) last_lsu = win_lsu;

    drive_edge();
    if_req_valid = iv; if_req_addr = ia;
    lsu_req_valid = lv; lsu_req_we = lwe; lsu_req_addr = la;
    lsu_req_wdata = lwd; lsu_req_wmask = lm;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    sample();
    chk("idle_if_ready", if_req_ready, iv && !win_lsu);
    chk("idle_lsu_ready", lsu_req_ready, win_lsu);
    chk_quiet("idle");
    order = {order[2:0], lsu_req_ready};

    for (int i = 0; i <= d; i++) begin
      drive_edge();
      if (!hold) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      mem_req_ready = (i == d);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data = $urandom;
      sample();
      chk("issue_valid", mem_req_valid, 1'b1);
      chk("issue_we", mem_req_we, win_lsu ? lwe : 1'b0);
      chk("issue_addr", mem_req_addr, win_lsu ? la : ia);
      chk("issue_wdata", mem_req_wdata, win_lsu ? lwd : 32'h0);
      chk("issue_wmask", mem_req_wmask, win_lsu ? lm : 4'h0);
      chk("issue_busy", busy, 1'b1);
      chk("issue_ready", {if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid}, 4'b0000);
    end

    for (int i = 0; i <= w; i++) begin
      drive_edge();
      mem_req_ready = 1'b0;
      mem_rsp_valid = (i == w);
      mem_rsp_data = (i == w) ? rdata : $urandom;
      sample();
      chk("wait_busy", busy, 1'b1);
      chk("wait_quiet", {mem_req_valid, if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid}, 5'b00000);
    end

    drive_edge();
    mem_rsp_valid = 1'($urandom_range(0, 1));
    mem_rsp_data = $urandom;
    sample();
    chk("resp_if_valid", if_rsp_valid, !win_lsu);
    chk("resp_lsu_valid", lsu_rsp_valid, win_lsu);
    if (win_lsu) chk("resp_lsu_data", lsu_rsp_data, rdata);
    else         chk("resp_if_data", if_rsp_data, rdata);
    chk("resp_quiet", {mem_req_valid, if_req_ready, lsu_req_ready}, 3'b000);
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    last_lsu = 1'b0;
    order = 4'h0;
    reset = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h44;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h88;
    lsu_req_wdata = 32'h55; lsu_req_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1;

    // Outputs stay low while reset is held, even with requests pending.
    sample();
    chk("rst_ready", {if_req_ready, lsu_req_ready}, 2'b00);
    chk_quiet("rst");
    drive_edge();
    sample();
    chk("rst2_ready", {if_req_ready, lsu_req_ready}, 2'b00);
    chk("rst2_addr", mem_req_addr, 32'h0);
    drive_edge();
    reset = 1'b0; if_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777;
    sample();
    chk_quiet("post_rst_spurious");
    chk("post_rst_data", if_rsp_data, 32'h0);
    drive_edge();
    mem_rsp_valid = 1'b0;
    sample();
    chk_quiet("post_spurious");

    do_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678, 4'h3, 3, 1, 32'h0BADF00D, 1'b0);

    // Reset during WAIT, then a late response that must be dropped.
    drive_edge();
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h300; mem_rsp_valid = 1'b0;
    sample();
    chk("rw_accept", lsu_req_ready, 1'b1);
    drive_edge();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    chk("rw_issue", mem_req_valid, 1'b1);
    drive_edge();
    mem_req_ready = 1'b0;
    sample();
    chk("rw_wait_busy", busy, 1'b1);
    drive_edge();
    reset = 1'b1;
    sample();
    chk_quiet("rw_in_reset");
    drive_edge();
    reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
    last_lsu = 1'b0;
    sample();
    chk_quiet("rw_late_rsp");
    drive_edge();
    mem_rsp_valid = 1'b0;
    sample();
    chk_quiet("rw_after");
    chk("rw_data", lsu_rsp_data, 32'h0);

    // Both requesters continuously valid for four transactions.
    for (int t = 0; t < 4; t++) begin
      do_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(t), 32'h2000 + 32'(t), 32'h0, 4'h0,
             t % 2, 0, 32'hA0 + 32'(t), 1'b1);
    end
    chk("tie_order", order, rr_en ? 4'b1010 : 4'b1111);

    for (int t = 0; t < 12; t++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(1, 3));
      do_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
             1'($urandom_range(0, 1)));
    end

    drive_edge();
    if_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5A5A;
    sample();
    chk_quiet("end_spurious");
    drive_edge();
    mem_rsp_valid = 1'b0;
    sample();
    chk_quiet("end_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width; byte-mask width is DATA_W/8.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: if_req_valid in 1, if_req_addr in ADDR_W, if_req_ready out 1  instruction-fetch read request.
REQ-006 Ports: if_rsp_valid out 1, if_rsp_data out DATA_W  fetch response.
REQ-007 Ports: lsu_req_valid in 1, lsu_req_we in 1, lsu_req_addr in ADDR_W, lsu_req_wdata in DATA_W, lsu_req_wmask in DATA_W/8, lsu_req_ready out 1  load/store request.
REQ-008 Ports: lsu_rsp_valid out 1, lsu_rsp_data out DATA_W  load data or store acknowledge.
REQ-009 Ports: mem_req_valid out 1, mem_req_ready in 1, mem_req_we out 1, mem_req_addr out ADDR_W, mem_req_wdata out DATA_W, mem_req_wmask out DATA_W/8  shared memory request.
REQ-010 Ports: mem_rsp_valid in 1, mem_rsp_data in DATA_W  memory response, one per accepted request.
REQ-011 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL share one memory port between the IF and LSU requesters, with at most one transaction outstanding.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE, *_req_ready SHALL be 1 only for the granted requester (combinational on the valids); accept = valid && ready; on accept, latch owner, we (IF forces 0), addr, wdata, wmask (IF forces 0), then go to ISSUE.
REQ-015 In ISSUE, mem_req_valid=1 with the latched fields held stable until mem_req_ready=1, then go to WAIT.
REQ-016 In WAIT, on mem_rsp_valid=1, register mem_rsp_data (stores included), then go to RESP.
REQ-017 In RESP, the owner's rsp_valid=1 for exactly one cycle with the registered data; the other requester's rsp_valid=0; go to IDLE.
REQ-018 No request SHALL be accepted outside IDLE; both req_ready=0 in ISSUE, WAIT and RESP.
REQ-019 Minimum latency: accept at cycle N; mem_req_valid at N+1; with mem_req_ready at N+1 and mem_rsp_valid at N+2, rsp_valid at N+3; back-to-back accept is possible at N+4.
REQ-020 mem_rsp_valid in IDLE, ISSUE or RESP SHALL be ignored with no state change.
REQ-021 mem_req_valid, if_rsp_valid and lsu_rsp_valid SHALL be 0 in every state except those named above.
REQ-022 Single requester valid in IDLE: that requester SHALL be granted.

Reset
REQ-023 While reset=1 at a rising edge: state=IDLE, last_grant=IF, latched fields and rsp data=0.
REQ-024 All outputs SHALL be 0 during and after reset until a new accept, regardless of the state when reset arrived.
REQ-025 A memory response arriving after a mid-transaction reset SHALL be discarded (REQ-020).

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on simultaneous valids in IDLE, grant the requester not granted last (last_grant updates on every accept); after reset, the first tie goes to LSU.
REQ-027 Macro MEM_ARB_RR_EN undefined: on simultaneous valids, LSU SHALL always win; last_grant is not implemented.

Verification
REQ-028 After reset, IF read addr 0x100, mem_req_ready=1 immediately, mem_rsp_valid one cycle later with data 0xDEADBEEF -> if_rsp_valid pulses at accept+3 with 0xDEADBEEF; lsu_rsp_valid stays 0.
REQ-029 LSU store addr 0x200, wdata 0x12345678, wmask 0x3, mem_req_ready delayed 3 cycles -> mem_req_* held stable for 4 cycles with we=1, wmask=0x3; lsu_rsp_valid pulses once after mem_rsp_valid.
REQ-030 IF and LSU both valid continuously for 4 transactions -> with MEM_ARB_RR_EN, grant order LSU, IF, LSU, IF; without it, LSU 4 times and if_req_ready never 1.
REQ-031 Reset asserted during WAIT, then mem_rsp_valid=1 with 0xCAFEF00D -> state IDLE, no rsp_valid pulse, busy=0.
REQ-032 Spurious mem_rsp_valid in IDLE with no requests -> no rsp_valid pulse, busy stays 0.
